mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Memory-side stage directly downstream of the datapath's memory address and data outputs.
- Accepts one word-addressed read/write request at a time from the control unit.
- Decodes the request to one of three targets: on-chip synchronous RAM (with configurable wait states), a memory-mapped IN port, or a memory-mapped OUT port.
- Returns read data for the write-back path and pulses a ready strobe so the control unit can advance its phase.

Parameters:
- RAM_AW, 9: RAM word-address width; RAM occupies word addresses 0 .. 2**RAM_AW-1.
- WAIT_STATES, 1: extra RAM cycles before read data is captured; legal range 0..15.
- IO_IN_ADDR, 32'hFFFF_FFF0: word address of the IN port (read only).
- IO_OUT_ADDR, 32'hFFFF_FFF1: word address of the OUT port (write, readback allowed).

Ports:
- iClk  in  1  system clock, rising edge.
- iRst  in  1  synchronous reset, active-high.
- iReq  in  1  request strobe; sampled only in IDLE.
- iWr  in  1  1 = write, 0 = read; qualified by iReq.
- iAddr  in  32  word address.
- iWData  in  32  write data.
- oRData  out  32  read data; held until the next completed read.
- oReady  out  1  one-cycle completion pulse.
- oErr  out  1  valid with oReady; 1 = unmapped or illegal access.
- oBusy  out  1  high whenever state != IDLE.
- oRamAddr  out  RAM_AW  RAM word address.
- oRamWData  out  32  RAM write data.
- oRamWe  out  1  RAM write strobe.
- oRamRe  out  1  RAM read strobe.
- iRamRData  in  32  RAM read data; valid the cycle after oRamRe.
- iInPort  in  32  external input port.
- oOutPort  out  32  registered output port.

Behaviour:
- Clock and reset: one clock, iClk. iRst is synchronous and active-high.
- Reset values: state = IDLE; oRData = 0; oOutPort = 0; oReady = 0; oErr = 0; oBusy = 0; all RAM strobes = 0; latched request = 0.
- States: IDLE, RAM, WAIT, DONE.
- IDLE: when iReq=1 at the rising edge, latch iAddr, iWr and iWData, then decode the latched request:
  - RAM hit (iAddr < 2**RAM_AW) -> go to RAM.
  - IN read: capture iInPort into oRData -> go to DONE.
  - OUT write: oOutPort <= iWData -> go to DONE.
  - OUT read: oRData <= oOutPort -> go to DONE.
  - IN write, or any other address: set the error flag, and if the access is a read set oRData <= 0 -> go to DONE. No other side effect.
- RAM (exactly 1 cycle):
  - oRamAddr = latched address low RAM_AW bits; oRamWData = latched data.
  - oRamWe = latched wr; oRamRe = ~latched wr.
  - Load the wait counter with WAIT_STATES, then go to WAIT.
- WAIT: strobes = 0 and the counter decrements each cycle. When the counter is 0, capture iRamRData into oRData (reads only) and go to DONE.
- DONE (exactly 1 cycle): oReady = 1; oErr = error flag. Then go to IDLE and clear the error flag.
- Latency, counting the cycle iReq is sampled as cycle 0:
  - IO or error access: oReady in cycle 1.
  - RAM access: oReady in cycle 3+WAIT_STATES (WAIT_STATES=1 gives cycle 4).
- oRamWe and oRamRe are each high exactly one cycle per RAM access and are never high together.
- Writes never modify oRData.
- iReq while oBusy=1 is ignored, not queued. A new request may be presented in the cycle after oReady; that is back-to-back operation.
- Reset mid-operation: all strobes drop and state returns to IDLE at the reset edge. There is no oReady for the aborted access. A RAM write already strobed is not undone.
- Address compare uses the full 32 bits. There is no wrap-around: an address of 2**RAM_AW or above that is neither IO address is an error.
- oOutPort changes only on a legal OUT write.

Decomposition:
- Shared include (constants.vh):
  - state encodings MBC_IDLE/MBC_RAM/MBC_WAIT/MBC_DONE (2-bit).
  - default IO_IN_ADDR and IO_OUT_ADDR.
  - target select codes TGT_RAM/TGT_IN/TGT_OUT/TGT_ERR.
- Sub-module mem_addr_decode (combinational): inputs iAddr and iWr; outputs a 2-bit target code and an illegal flag. It is reused by the system-level address-map checker.
- FSM, wait counter, output registers and the IO register stay in mem_bus_ctrl.

Test Plan:
- RAM write then read (WAIT_STATES=1): write 32'hDEAD_BEEF to addr 5 -> oRamWe=1 for one cycle with oRamAddr=5, oReady in cycle 4, oErr=0. Read addr 5 -> oRamRe for one cycle, oRData=32'hDEAD_BEEF at oReady in cycle 4.
- IO: iInPort=32'h0000_1234, read IO_IN_ADDR -> oReady in cycle 1, oRData=32'h1234. Write 32'hA5 to IO_OUT_ADDR -> oOutPort=32'hA5 in cycle 1. Read IO_OUT_ADDR -> oRData=32'hA5.
- Errors: read addr 32'h0000_0200 (RAM_AW=9) -> oReady and oErr=1 in cycle 1, oRData=0, no RAM strobe. Write IO_IN_ADDR -> oErr=1, oOutPort unchanged.
- Busy and back-to-back: hold iReq=1 continuously with a RAM read -> the second request is accepted only in the cycle after oReady. Pulses of iReq during WAIT produce no extra access.
- Reset mid-access: assert iRst during WAIT of a RAM read -> next cycle state=IDLE, oReady never pulses, oRData=0, oOutPort=0.
- WAIT_STATES=0 and WAIT_STATES=3 builds: RAM read oReady in cycle 3 and cycle 6 respectively, data correct.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus controller: FSM states, decode
// target codes, default IO port addresses and a RAM range helper.
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        MBC_IDLE = 2'd0,
        MBC_RAM  = 2'd1,
        MBC_WAIT = 2'd2,
        MBC_DONE = 2'd3
    } mbc_state_t;

    typedef enum logic [1:0] {
        TGT_RAM = 2'd0,
        TGT_IN  = 2'd1,
        TGT_OUT = 2'd2,
        TGT_ERR = 2'd3
    } mbc_target_t;

    localparam logic [31:0] DEF_IO_IN_ADDR  = 32'hFFFF_FFF0;
    localparam logic [31:0] DEF_IO_OUT_ADDR = 32'hFFFF_FFF1;

    // Width of the wait-state counter (wait states 0..15).
    localparam int WAIT_CNT_W = 4;

    // True when the full 32-bit word address falls inside the RAM window.
    // No wrap-around: any set bit above the RAM address width misses.
    function automatic logic in_ram_range(input logic [31:0] addr, input int unsigned aw);
        return (addr >> aw) == 32'd0;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_decode.sv
// Combinational address decoder: maps a word address and direction to a
// target code plus an illegal-access flag. Shared with the system-level
// address-map checker, so it carries no state.
module mem_addr_decode
    import mem_bus_ctrl_pkg::*;
#(
    parameter int          RAM_AW      = 9,
    parameter logic [31:0] IO_IN_ADDR  = DEF_IO_IN_ADDR,
    parameter logic [31:0] IO_OUT_ADDR = DEF_IO_OUT_ADDR
) (
    input  logic [31:0] iAddr,
    input  logic        iWr,
    output mbc_target_t oTarget,
    output logic        oIllegal
);

    // Priority decode: RAM window, then IN (read only), then OUT.
    always_comb begin
        oTarget  = TGT_ERR;
        oIllegal = 1'b1;
        if (in_ram_range(iAddr, RAM_AW)) begin
            oTarget  = TGT_RAM;
            oIllegal = 1'b0;
        end else if (iAddr == IO_IN_ADDR) begin
            if (!iWr) begin
                oTarget  = TGT_IN;
                oIllegal = 1'b0;
            end
        end else if (iAddr == IO_OUT_ADDR) begin
            oTarget  = TGT_OUT;
            oIllegal = 1'b0;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus stage: takes one word-addressed request at a time,
// routes it to on-chip RAM (with wait states) or the IN/OUT ports, and
// returns read data with a one-cycle ready pulse.
//
// Handshake: iReq is sampled only while oBusy is low (IDLE); a sampled
// request is accepted unconditionally and oBusy rises the next cycle.
// Requests seen while oBusy is high are dropped, never queued. Completion
// is a single-cycle oReady pulse with oErr valid alongside it; the next
// request may be presented in the cycle after oReady.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int          RAM_AW      = 9,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] IO_IN_ADDR  = DEF_IO_IN_ADDR,
    parameter logic [31:0] IO_OUT_ADDR = DEF_IO_OUT_ADDR
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iReq,
    input  logic              iWr,
    input  logic [31:0]       iAddr,
    input  logic [31:0]       iWData,
    output logic [31:0]       oRData,
    output logic              oReady,
    output logic              oErr,
    output logic              oBusy,
    output logic [RAM_AW-1:0] oRamAddr,
    output logic [31:0]       oRamWData,
    output logic              oRamWe,
    output logic              oRamRe,
    input  logic [31:0]       iRamRData,
    input  logic [31:0]       iInPort,
    output logic [31:0]       oOutPort,
    output logic [1:0]        oDbgState
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = 4'(WAIT_STATES);

    mbc_state_t              state_q, state_d;
    mbc_target_t             tgt;
    logic                    illegal;
    logic [RAM_AW-1:0]       ram_addr_q;
    logic                    wr_q;
    logic [31:0]             wdata_q;
    logic                    err_q;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q;
    logic [31:0]             rdata_q;
    logic [31:0]             out_q;

    // The incoming address is decoded in the same edge it is latched, so an
    // IO or error access completes one cycle after it is sampled.
    mem_addr_decode #(
        .RAM_AW      (RAM_AW),
        .IO_IN_ADDR  (IO_IN_ADDR),
        .IO_OUT_ADDR (IO_OUT_ADDR)
    ) u_decode (
        .iAddr    (iAddr),
        .iWr      (iWr),
        .oTarget  (tgt),
        .oIllegal (illegal)
    );

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= MBC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-derived strobes.
    always_comb begin
        state_d = state_q;
        oRamWe  = 1'b0;
        oRamRe  = 1'b0;
        oReady  = 1'b0;
        oErr    = 1'b0;
        oBusy   = (state_q != MBC_IDLE);
        case (state_q)
            MBC_IDLE: begin
                if (iReq) begin
                    state_d = (tgt == TGT_RAM) ? MBC_RAM : MBC_DONE;
                end
            end
            MBC_RAM: begin
                oRamWe  = wr_q;
                oRamRe  = ~wr_q;
                state_d = MBC_WAIT;
            end
            MBC_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = MBC_DONE;
                end
            end
            MBC_DONE: begin
                oReady  = 1'b1;
                oErr    = err_q;
                state_d = MBC_IDLE;
            end
            default: state_d = MBC_IDLE;
        endcase
    end

    // Request latch, wait counter, read-data and OUT port registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            ram_addr_q <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
            rdata_q    <= '0;
            out_q      <= '0;
        end else begin
            case (state_q)
                MBC_IDLE: begin
                    if (iReq) begin
                        ram_addr_q <= iAddr[RAM_AW-1:0];
                        wr_q       <= iWr;
                        wdata_q    <= iWData;
                        err_q      <= illegal;
                        case (tgt)
                            TGT_IN:  rdata_q <= iInPort;
                            TGT_OUT: begin
                                if (iWr) begin
                                    out_q <= iWData;
                                end else begin
                                    rdata_q <= out_q;
                                end
                            end
                            TGT_ERR: begin
                                if (!iWr) begin
                                    rdata_q <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MBC_RAM: begin
                    wait_cnt_q <= WAIT_LOAD;
                end
                MBC_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        if (!wr_q) begin
                            rdata_q <= iRamRData;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                MBC_DONE: begin
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign oRamAddr  = ram_addr_q;
    assign oRamWData = wdata_q;
    assign oRData    = rdata_q;
    assign oOutPort  = out_q;
    assign oDbgState = state_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: three instances (WAIT_STATES = 1, 0, 3) each with
// a behavioural synchronous RAM. Instance 0 runs the directed table, the
// busy/back-to-back and reset sequences, and randomized traffic against a
// reference model; instances 1 and 2 check wait-state latency.
module tb_mem_bus_ctrl;

  localparam int          N    = 3;
  localparam logic [31:0] IN_A  = 32'hFFFF_FFF0;
  localparam logic [31:0] OUT_A = 32'hFFFF_FFF1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic ram_init;
  always #5 clk = ~clk;

  logic        req [N];
  logic        wr [N];
  logic [31:0] addr [N];
  logic [31:0] wdata [N];
  logic [31:0] rdata [N];
  logic        ready [N];
  logic        err [N];
  logic        busy [N];
  logic [8:0]  ram_addr [N];
  logic [31:0] ram_wdata [N];
  logic        ram_we [N];
  logic        ram_re [N];
  logic [31:0] ram_rdata [N];
  logic [31:0] out_port [N];
  logic [1:0]  dbg [N];
  logic [31:0] in_port;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    mem_bus_ctrl #(
      .RAM_AW      (9),
      .WAIT_STATES (WS),
      .IO_IN_ADDR  (IN_A),
      .IO_OUT_ADDR (OUT_A)
    ) u_dut (
      .iClk      (clk),
      .iRst      (rst),
      .iReq      (req[g]),
      .iWr       (wr[g]),
      .iAddr     (addr[g]),
      .iWData    (wdata[g]),
      .oRData    (rdata[g]),
      .oReady    (ready[g]),
      .oErr      (err[g]),
      .oBusy     (busy[g]),
      .oRamAddr  (ram_addr[g]),
      .oRamWData (ram_wdata[g]),
      .oRamWe    (ram_we[g]),
      .oRamRe    (ram_re[g]),
      .iRamRData (ram_rdata[g]),
      .iInPort   (in_port),
      .oOutPort  (out_port[g]),
      .oDbgState (dbg[g])
    );
  end

  // Behavioural synchronous RAMs plus strobe monitors.
  logic [31:0] mem [N][512];
  int          we_cnt [N];
  int          re_cnt [N];
  int          both_cnt [N];
  logic [8:0]  last_addr [N];
  logic [31:0] last_wdata [N];

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (ram_init) begin
        for (int i = 0; i < 512; i++) mem[k][i] <= '0;
        ram_rdata[k]  <= '0;
        we_cnt[k]     <= 0;
        re_cnt[k]     <= 0;
        both_cnt[k]   <= 0;
        last_addr[k]  <= '0;
        last_wdata[k] <= '0;
      end else begin
        if (ram_we[k]) begin
          mem[k][ram_addr[k]] <= ram_wdata[k];
          we_cnt[k]     <= we_cnt[k] + 1;
          last_addr[k]  <= ram_addr[k];
          last_wdata[k] <= ram_wdata[k];
        end
        if (ram_re[k]) begin
          ram_rdata[k] <= mem[k][ram_addr[k]];
          re_cnt[k]    <= re_cnt[k] + 1;
          last_addr[k] <= ram_addr[k];
        end
        if (ram_we[k] && ram_re[k]) both_cnt[k] <= both_cnt[k] + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one request in an idle cycle, then waits (bounded) for oReady.
  // Returns the latency counted from the sampling cycle (cycle 0); on return
  // the bench sits in the oReady cycle.
  task automatic access(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic e);
    @(negedge clk);
    req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d;
    @(negedge clk);
    req[k] = 1'b0;
    lat = 1;
    while (ready[k] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = err[k];
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] inport;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] outp;
    int          we;
    int          re;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  // Reference model state for instance 0.
  logic [31:0] m_ram [512];
  logic [31:0] m_out;
  logic [31:0] m_rdata;

  initial begin
    int          lat;
    logic        e;
    int          w0, r0, b0;
    int          rdy_c[$];
    int          re_c[$];
    int          cat;
    logic        w;
    logic [31:0] a, d;
    int          e_lat, e_we, e_re;
    logic        e_err;
    int          cnt_rdy, cnt_re, cnt_we;

    //            wr    addr          wdata          inport        lat err   rdata          outp    we re
    vt[0]  = '{1'b1, 32'd5,        32'hDEAD_BEEF, 32'd0,        4, 1'b0, 32'd0,         32'd0,  1, 0};
    vt[1]  = '{1'b0, 32'd5,        32'd0,         32'd0,        4, 1'b0, 32'hDEAD_BEEF, 32'd0,  0, 1};
    vt[2]  = '{1'b0, IN_A,         32'd0,         32'h1234,     1, 1'b0, 32'h1234,      32'd0,  0, 0};
    vt[3]  = '{1'b1, OUT_A,        32'hA5,        32'd0,        1, 1'b0, 32'h1234,      32'hA5, 0, 0};
    vt[4]  = '{1'b0, OUT_A,        32'd0,         32'd0,        1, 1'b0, 32'hA5,        32'hA5, 0, 0};
    vt[5]  = '{1'b0, 32'h200,      32'd0,         32'd0,        1, 1'b1, 32'd0,         32'hA5, 0, 0};
    vt[6]  = '{1'b1, IN_A,         32'h77,        32'h5555,     1, 1'b1, 32'd0,         32'hA5, 0, 0};
    vt[7]  = '{1'b1, 32'h1FF,      32'h1234_5678, 32'd0,        4, 1'b0, 32'd0,         32'hA5, 1, 0};
    vt[8]  = '{1'b0, 32'h1FF,      32'd0,         32'd0,        4, 1'b0, 32'h1234_5678, 32'hA5, 0, 1};
    vt[9]  = '{1'b1, 32'hFFFF_FFF2, 32'h99,       32'd0,        1, 1'b1, 32'h1234_5678, 32'hA5, 0, 0};
    vt[10] = '{1'b0, 32'h8000_0005, 32'd0,        32'd0,        1, 1'b1, 32'd0,         32'hA5, 0, 0};
    vt[11] = '{1'b1, 32'd0,        32'hCAFE,      32'd0,        4, 1'b0, 32'd0,         32'hA5, 1, 0};

    for (int k = 0; k < N; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    in_port  = '0;
    rst      = 1'b1;
    ram_init = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst rdata", rdata[0], 32'd0);
    check("rst out", out_port[0], 32'd0);
    check("rst ready", {31'd0, ready[0]}, 32'd0);
    check("rst err", {31'd0, err[0]}, 32'd0);
    check("rst busy", {31'd0, busy[0]}, 32'd0);
    check("rst strobes", {30'd0, ram_we[0], ram_re[0]}, 32'd0);
    check("rst state", {30'd0, dbg[0]}, 32'd0);
    rst      = 1'b0;
    ram_init = 1'b0;
    @(negedge clk);

    // Directed table on instance 0 (WAIT_STATES = 1).
    for (int i = 0; i < NV; i++) begin
      in_port = vt[i].inport;
      w0 = we_cnt[0]; r0 = re_cnt[0]; b0 = both_cnt[0];
      access(0, vt[i].wr, vt[i].addr, vt[i].wdata, lat, e);
      check($sformatf("vec%0d lat", i), lat, vt[i].lat);
      check($sformatf("vec%0d err", i), {31'd0, e}, {31'd0, vt[i].err});
      check($sformatf("vec%0d rdata", i), rdata[0], vt[i].rdata);
      check($sformatf("vec%0d out", i), out_port[0], vt[i].outp);
      check($sformatf("vec%0d we", i), we_cnt[0] - w0, vt[i].we);
      check($sformatf("vec%0d re", i), re_cnt[0] - r0, vt[i].re);
      check($sformatf("vec%0d both", i), both_cnt[0] - b0, 0);
      if (vt[i].we + vt[i].re > 0)
        check($sformatf("vec%0d ram_addr", i), {23'd0, last_addr[0]}, {23'd0, vt[i].addr[8:0]});
      if (vt[i].we > 0)
        check($sformatf("vec%0d ram_wdata", i), last_wdata[0], vt[i].wdata);
    end

    // Bring the reference model in line with the table's effects.
    for (int i = 0; i < 512; i++) m_ram[i] = '0;
    m_ram[5]     = 32'hDEAD_BEEF;
    m_ram[9'h1FF] = 32'h1234_5678;
    m_ram[0]     = 32'hCAFE;
    m_out        = 32'hA5;
    m_rdata      = 32'd0;

    // Back-to-back: iReq held high with a RAM read of address 5.
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'd5;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (ready[0]) rdy_c.push_back(c);
      if (ram_re[0]) re_c.push_back(c);
      if (c == 9) req[0] = 1'b0;
    end
    check("b2b ready count", rdy_c.size(), 2);
    check("b2b ready first", rdy_c.size() > 0 ? rdy_c[0] : -1, 4);
    check("b2b ready second", rdy_c.size() > 1 ? rdy_c[1] : -1, 9);
    check("b2b re count", re_c.size(), 2);
    check("b2b re first", re_c.size() > 0 ? re_c[0] : -1, 1);
    check("b2b re second", re_c.size() > 1 ? re_c[1] : -1, 6);
    check("b2b rdata", rdata[0], 32'hDEAD_BEEF);
    m_rdata = 32'hDEAD_BEEF;

    // Request pulses during WAIT are dropped.
    cnt_rdy = 0; cnt_re = 0; cnt_we = 0;
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h1FF;
    @(negedge clk);
    req[0] = 1'b0;
    if (ram_re[0]) cnt_re++;
    @(negedge clk);
    check("wait busy", {31'd0, busy[0]}, 32'd1);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'd5; wdata[0] = 32'h0BAD;
    for (int c = 3; c <= 12; c++) begin
      @(negedge clk);
      if (c == 4) req[0] = 1'b0;
      if (ready[0]) cnt_rdy++;
      if (ram_re[0]) cnt_re++;
      if (ram_we[0]) cnt_we++;
    end
    check("waitpulse ready", cnt_rdy, 1);
    check("waitpulse re", cnt_re, 1);
    check("waitpulse we", cnt_we, 0);
    check("waitpulse rdata", rdata[0], 32'h1234_5678);
    m_rdata = 32'h1234_5678;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      cat = $urandom_range(0, 3);
      w   = 1'($urandom_range(0, 1));
      d   = $urandom;
      in_port = $urandom;
      case (cat)
        0:       a = $urandom_range(0, 15);
        1:       a = IN_A;
        2:       a = OUT_A;
        default: a = 32'h200 + $urandom_range(0, 32'hFFFF_FDEF);
      endcase
      e_err = 1'b0; e_lat = 1; e_we = 0; e_re = 0;
      if (a < 32'd512) begin
        e_lat = 4;
        if (w) begin m_ram[a[8:0]] = d; e_we = 1; end
        else begin m_rdata = m_ram[a[8:0]]; e_re = 1; end
      end else if (a == IN_A && !w) begin
        m_rdata = in_port;
      end else if (a == OUT_A) begin
        if (w) m_out = d;
        else m_rdata = m_out;
      end else begin
        e_err = 1'b1;
        if (!w) m_rdata = '0;
      end
      w0 = we_cnt[0]; r0 = re_cnt[0]; b0 = both_cnt[0];
      access(0, w, a, d, lat, e);
      check($sformatf("rnd%0d lat", n), lat, e_lat);
      check($sformatf("rnd%0d err", n), {31'd0, e}, {31'd0, e_err});
      check($sformatf("rnd%0d rdata", n), rdata[0], m_rdata);
      check($sformatf("rnd%0d out", n), out_port[0], m_out);
      check($sformatf("rnd%0d strobes", n), {(we_cnt[0] - w0), (re_cnt[0] - r0), (both_cnt[0] - b0)} == {e_we, e_re, 0} ? 32'd1 : 32'd0, 32'd1);
    end

    // Reset during WAIT of a RAM read.
    access(0, 1'b1, OUT_A, 32'h5A5A, lat, e);
    access(0, 1'b0, OUT_A, 32'd0, lat, e);
    check("pre-rst rdata", rdata[0], 32'h5A5A);
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'd5;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst state", {30'd0, dbg[0]}, 32'd0);
    check("midrst busy", {31'd0, busy[0]}, 32'd0);
    check("midrst rdata", rdata[0], 32'd0);
    check("midrst out", out_port[0], 32'd0);
    check("midrst strobes", {30'd0, ram_we[0], ram_re[0]}, 32'd0);
    rst = 1'b0;
    cnt_rdy = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ready[0]) cnt_rdy++;
    end
    check("midrst no ready", cnt_rdy, 0);

    // Wait-state builds: instance 1 (0 wait states), instance 2 (3).
    for (int k = 1; k < N; k++) begin
      int ws;
      ws = (k == 1) ? 0 : 3;
      d  = $urandom;
      access(k, 1'b1, 32'd9, d, lat, e);
      check($sformatf("ws%0d wr lat", ws), lat, 3 + ws);
      check($sformatf("ws%0d wr err", ws), {31'd0, e}, 32'd0);
      access(k, 1'b0, 32'd9, 32'd0, lat, e);
      check($sformatf("ws%0d rd lat", ws), lat, 3 + ws);
      check($sformatf("ws%0d rd err", ws), {31'd0, e}, 32'd0);
      check($sformatf("ws%0d rd data", ws), rdata[k], d);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
